key_cmd_sequencer: RTL and testbench

//   Sits between the keypad scanner and the I2C EEPROM controller. Converts debounced key codes into a
//   two-digit data entry (hi/lo nibbles) and into timed CMD_WR / CMD_RD pulses for the I2C block.

---
 rtl/key_cmd_sequencer_if.sv | 22 ++
 rtl/key_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_key_cmd_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_cmd_sequencer_if.sv
// Keypad-side and I2C-side signal bundle for key_cmd_sequencer.
// The master modport is the stimulus/observer side; the slave modport is the sequencer.
interface key_cmd_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       cmd_wr;
    logic       cmd_rd;
    logic [3:0] data_lo;
    logic [3:0] data_hi;
    logic       seq_busy;
    logic       key_rej;

    modport master (
        output key_valid, key_code,
        input  cmd_wr, cmd_rd, data_lo, data_hi, seq_busy, key_rej
    );

    modport slave (
        input  key_valid, key_code,
        output cmd_wr, cmd_rd, data_lo, data_hi, seq_busy, key_rej
    );
endinterface

// File: rtl/key_cmd_sequencer.sv
// Turns debounced key codes into a two-digit data entry and timed EEPROM write/read command pulses.
// Optional macro AUTO_READBACK_EN: a completed write is followed automatically by a read.
module key_cmd_sequencer #(
    parameter int unsigned CMD_PULSE_CYC = 1000,
    parameter int unsigned WR_WAIT_CYC   = 250000,
    parameter int unsigned RD_WAIT_CYC   = 50000,
    parameter logic [3:0]  KEY_WR        = 4'hA,
    parameter logic [3:0]  KEY_RD        = 4'hB,
    parameter logic [3:0]  KEY_CLR       = 4'hC
) (
    input logic                clk,
    input logic                reset,
    key_cmd_sequencer_if.slave bus
);

    localparam int unsigned MAX_AB  = (CMD_PULSE_CYC > WR_WAIT_CYC) ? CMD_PULSE_CYC : WR_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > RD_WAIT_CYC) ? MAX_AB : RD_WAIT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(CMD_PULSE_CYC);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_WAIT_CYC);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_PULSE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_PULSE = 3'd3,
        RD_WAIT  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       data_lo, data_lo_nxt;
    logic [3:0]       data_hi, data_hi_nxt;
    logic             key_rej, key_rej_nxt;
    logic             key_valid_p1;
    logic             key_event;
    logic             cnt_done;

    assign key_event = bus.key_valid & ~key_valid_p1;
    assign cnt_done  = (cnt <= CNT_ONE);

    // Register stage: everything, including the entered digits, is cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            data_lo      <= 4'd0;
            data_hi      <= 4'd0;
            key_rej      <= 1'b0;
            key_valid_p1 <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            data_lo      <= data_lo_nxt;
            data_hi      <= data_hi_nxt;
            key_rej      <= key_rej_nxt;
            key_valid_p1 <= bus.key_valid;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        data_lo_nxt = data_lo;
        data_hi_nxt = data_hi;
        key_rej_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (key_event) begin
                    if (bus.key_code <= 4'd9) begin
                        data_hi_nxt = data_lo;
                        data_lo_nxt = bus.key_code;
                    end else if (bus.key_code == KEY_CLR) begin
                        data_hi_nxt = 4'd0;
                        data_lo_nxt = 4'd0;
                    end else if (bus.key_code == KEY_WR) begin
                        state_nxt = WR_PULSE;
                        cnt_nxt   = PULSE_LD;
                    end else if (bus.key_code == KEY_RD) begin
                        state_nxt = RD_PULSE;
                        cnt_nxt   = PULSE_LD;
                    end
                end
            end
            WR_PULSE: begin
                if (cnt_done) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = WR_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt_done) begin
`ifdef AUTO_READBACK_EN
                    state_nxt = RD_PULSE;
                    cnt_nxt   = PULSE_LD;
`else
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RD_PULSE: begin
                if (cnt_done) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = RD_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RD_WAIT: begin
                if (cnt_done) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Any key press while a command runs is dropped, even on the cycle that returns to IDLE.
        if (key_event && (state != IDLE)) begin
            key_rej_nxt = 1'b1;
        end
    end

    // Command strobes decode straight from state so an asynchronous reset drops them at once.
    assign bus.cmd_wr   = (state == WR_PULSE);
    assign bus.cmd_rd   = (state == RD_PULSE);
    assign bus.seq_busy = (state != IDLE);
    assign bus.data_lo  = data_lo;
    assign bus.data_hi  = data_hi;
    assign bus.key_rej  = key_rej;

endmodule

// File: tb/tb_key_cmd_sequencer.sv
// Self-checking bench for key_cmd_sequencer: directed scenarios plus random key traffic,
// compared cycle by cycle against a schedule-based reference model.
module tb_key_cmd_sequencer;

    localparam int P = 4;
    localparam int W = 20;
    localparam int R = 10;
`ifdef AUTO_READBACK_EN
    localparam int EXP_BUSY = 2 * P + W + R;
    localparam int EXP_RD   = P;
`else
    localparam int EXP_BUSY = P + W;
    localparam int EXP_RD   = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    key_cmd_sequencer_if bus();

    key_cmd_sequencer #(
        .CMD_PULSE_CYC(P),
        .WR_WAIT_CYC  (W),
        .RD_WAIT_CYC  (R),
        .KEY_WR       (4'hA),
        .KEY_RD       (4'hB),
        .KEY_CLR      (4'hC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: absolute edge windows for each command and for busy.
    int         edge_n    = 0;
    int         wr_first  = -1, wr_last = -1;
    int         rd_first  = -1, rd_last = -1;
    int         busy_last = -1;
    int         rej_edge  = -1;
    bit         m_prev    = 1'b0;
    logic [3:0] m_lo      = 4'd0;
    logic [3:0] m_hi      = 4'd0;

    typedef struct packed {
        logic       kv;
        logic [3:0] kc;
    } stim_t;
    stim_t stim_q[$];

    function automatic void model_reset();
        wr_first = -1; wr_last = -1; rd_first = -1; rd_last = -1;
        busy_last = -1; rej_edge = -1; m_prev = 1'b0; m_lo = 4'd0; m_hi = 4'd0;
    endfunction

    function automatic void model_edge(input logic kv, input logic [3:0] kc);
        bit ev, busy_before;
        ev          = kv && !m_prev;
        m_prev      = kv;
        busy_before = (busy_last >= edge_n - 1);
        if (ev && busy_before) rej_edge = edge_n;
        if (ev && !busy_before) begin
            if (kc <= 4'd9) begin
                m_hi = m_lo;
                m_lo = kc;
            end else if (kc == 4'hC) begin
                m_hi = 4'd0;
                m_lo = 4'd0;
            end else if (kc == 4'hA) begin
                wr_first  = edge_n;
                wr_last   = edge_n + P - 1;
                busy_last = edge_n + P + W - 1;
`ifdef AUTO_READBACK_EN
                rd_first  = edge_n + P + W;
                rd_last   = rd_first + P - 1;
                busy_last = rd_last + R;
`endif
            end else if (kc == 4'hB) begin
                rd_first  = edge_n;
                rd_last   = edge_n + P - 1;
                busy_last = edge_n + P + R - 1;
            end
        end
    endfunction

    function automatic logic [11:0] exp_vec();
        logic wr, rd, busy, rej;
        wr   = (edge_n >= wr_first) && (edge_n <= wr_last);
        rd   = (edge_n >= rd_first) && (edge_n <= rd_last);
        busy = (edge_n <= busy_last);
        rej  = (edge_n == rej_edge);
        return {wr, rd, busy, rej, m_hi, m_lo};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {bus.cmd_wr, bus.cmd_rd, bus.seq_busy, bus.key_rej, bus.data_hi, bus.data_lo};
    endfunction

    function automatic void add_key(input logic [3:0] code, input int hold, input int gap);
        for (int i = 0; i < hold; i++) stim_q.push_back('{kv: 1'b1, kc: code});
        for (int i = 0; i < gap; i++)  stim_q.push_back('{kv: 1'b0, kc: code});
    endfunction

    task automatic tick(input logic kv, input logic [3:0] kc);
        bus.key_valid = kv;
        bus.key_code  = kc;
        @(posedge clk);
        edge_n++;
        model_edge(kv, kc);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state observed %h expected %h", obs_vec(), 12'h000);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_entry();
        stim_q.delete();
        add_key(4'h3, 2, 2);
        add_key(4'h7, 2, 2);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL entry[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (obs_vec() !== 12'h037) begin
            n_bad++;
            $display("FAIL entry_final observed %h expected %h", obs_vec(), 12'h037);
        end
    endtask

    task automatic test_write();
        int busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;
        stim_q.delete();
        add_key(4'hA, 1, 45);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            busy_cnt += bus.seq_busy;
            wr_cnt   += bus.cmd_wr;
            rd_cnt   += bus.cmd_rd;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL write[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (busy_cnt != EXP_BUSY || wr_cnt != P || rd_cnt != EXP_RD || bus.data_hi !== 4'h3 || bus.data_lo !== 4'h7) begin
            n_bad++;
            $display("FAIL write_totals observed busy=%0d wr=%0d rd=%0d data=%h%h expected busy=%0d wr=%0d rd=%0d data=37",
                     busy_cnt, wr_cnt, rd_cnt, bus.data_hi, bus.data_lo, EXP_BUSY, P, EXP_RD);
        end
    endtask

    task automatic test_hold();
        int rej_cnt = 0;
        stim_q.delete();
        add_key(4'h5, 50, 2);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            rej_cnt += bus.key_rej;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL hold[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (rej_cnt != 0 || bus.data_hi !== 4'h7 || bus.data_lo !== 4'h5) begin
            n_bad++;
            $display("FAIL hold_result observed rej=%0d data=%h%h expected rej=0 data=75", rej_cnt, bus.data_hi, bus.data_lo);
        end
    endtask

    task automatic test_read_reject(input int gap_b, input string tag);
        int rej_cnt = 0, busy_cnt = 0;
        stim_q.delete();
        add_key(4'hB, 1, gap_b);
        add_key(4'h9, 1, 12);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            rej_cnt  += bus.key_rej;
            busy_cnt += bus.seq_busy;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL %s[%0d] observed %h expected %h", tag, i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (rej_cnt != 1 || busy_cnt != P + R || bus.data_hi !== 4'h7 || bus.data_lo !== 4'h5) begin
            n_bad++;
            $display("FAIL %s_totals observed rej=%0d busy=%0d data=%h%h expected rej=1 busy=%0d data=75",
                     tag, rej_cnt, busy_cnt, bus.data_hi, bus.data_lo, P + R);
        end
    endtask

    task automatic test_clear();
        int rej_cnt = 0;
        stim_q.delete();
        add_key(4'h4, 1, 1);
        add_key(4'h2, 1, 1);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear_entry[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (obs_vec() !== 12'h042) begin
            n_bad++;
            $display("FAIL clear_pre observed %h expected %h", obs_vec(), 12'h042);
        end
        stim_q.delete();
        add_key(4'hC, 1, 1);
        add_key(4'hE, 3, 2);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            rej_cnt += bus.key_rej;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (obs_vec() !== 12'h000 || rej_cnt != 0) begin
            n_bad++;
            $display("FAIL clear_post observed %h rej=%0d expected 000 rej=0", obs_vec(), rej_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int wr_cnt = 0;
        add_key(4'h6, 1, 1);
        stim_q.delete();
        tick(1'b1, 4'h6);
        tick(1'b0, 4'h6);
        tick(1'b1, 4'hA);
        tick(1'b0, 4'hA);
        n_cmp++;
        if (bus.cmd_wr !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre observed cmd_wr=%b expected 1", bus.cmd_wr);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_mid_async observed %h expected %h", obs_vec(), 12'h000);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stim_q.delete();
        add_key(4'hA, 1, 45);
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            wr_cnt += bus.cmd_wr;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid_write[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (wr_cnt != P) begin
            n_bad++;
            $display("FAIL reset_mid_wr_len observed %0d expected %0d", wr_cnt, P);
        end
    endtask

    task automatic test_random();
        stim_q.delete();
        for (int k = 0; k < 250; k++) begin
            add_key(4'($urandom_range(0, 15)), $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 3));
        end
        foreach (stim_q[i]) begin
            tick(stim_q[i].kv, stim_q[i].kc);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d] observed %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_write();
        test_hold();
        test_read_reject(6, "read_reject");
        test_read_reject(P + R - 1, "return_edge");
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
